// File: rtl/sc_ctrl_pkg.sv
// Shared control-path definitions for the SC decoder stage scheduler:
// FSM state type, stage-cost rule and width helpers.
package sc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_t;

    function automatic int unsigned stage_w(input int unsigned nn);
        return (nn > 1) ? $clog2(nn) : 1;
    endfunction

    function automatic int unsigned pe_w(input int unsigned nn, input int unsigned p);
        return (nn > p + 1) ? nn - 1 - p : 1;
    endfunction

    // Cycles a stage occupies when its 2^s LLR pairs share 2^p PEs.
    function automatic int unsigned stage_cost(input int unsigned s, input int unsigned p);
        return (s > p) ? (32'd1 << (s - p)) : 32'd1;
    endfunction

    localparam int unsigned N_DEFAULT     = 3;
    localparam int unsigned P_LOG_DEFAULT = 1;
    localparam int unsigned STAGE_W       = stage_w(N_DEFAULT);
    localparam int unsigned PE_W          = pe_w(N_DEFAULT, P_LOG_DEFAULT);

endpackage

// File: rtl/sc_trailing_zero_count.sv
// Combinational trailing-zero count; gives the entry stage of the next bit.
module sc_trailing_zero_count
    import sc_ctrl_pkg::*;
#(
    parameter  int unsigned n  = N_DEFAULT,
    localparam int unsigned SW = stage_w(n)
) (
    input  logic [n-1:0]  value,
    output logic [SW-1:0] count
);

    logic found;

    always_comb begin
        count = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            if (!found && value[i]) begin
                count = SW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_stage_scheduler.sv
// Stage sequencer for the semi-parallel SC decoder: walks every bit of one
// codeword, issuing (stage, f/g, pe sub-cycle) operations back to back.
module sc_stage_scheduler
    import sc_ctrl_pkg::*;
#(
    parameter  int unsigned n     = N_DEFAULT,
    parameter  int unsigned P_LOG = P_LOG_DEFAULT,
    localparam int unsigned SW    = stage_w(n),
    localparam int unsigned PW    = pe_w(n, P_LOG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    output logic          en,
    output logic [SW-1:0] stage_index,
    output logic          op_g,
    output logic [PW-1:0] pe_cycle,
    output logic [n-1:0]  bit_cnt,
    output logic          busy,
    output logic          done
);

    sched_state_t  state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [PW-1:0] pe_q, pe_d;
    logic [n-1:0]  bit_q, bit_d;
    logic          op_q, op_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [n-1:0]  bit_inc;
    logic [SW-1:0] entry_stage;
    logic [SW-1:0] stage_dec;
    logic [PW-1:0] pe_last;

    assign bit_inc   = bit_q + n'(1);
    assign stage_dec = stage_q - SW'(1);
    assign pe_last   = PW'(stage_cost(32'(stage_q), P_LOG) - 32'd1);

    sc_trailing_zero_count #(.n(n)) u_ctz (
        .value (bit_inc),
        .count (entry_stage)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        pe_d    = pe_q;
        bit_d   = bit_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = SW'(n - 1);
                    pe_d    = '0;
                    bit_d   = '0;
                    op_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (pe_q != pe_last) begin
                        pe_d = pe_q + PW'(1);
                    end else begin
                        pe_d = '0;
                        if (stage_q != '0) begin
                            stage_d = stage_dec;
                            op_d    = bit_q[stage_dec];
                        end else if (&bit_q) begin
                            state_d = DONE;
                            stage_d = '0;
                            bit_d   = '0;
                            op_d    = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            // Entry stage of bit i is ctz(i), where bit i is 1.
                            bit_d   = bit_inc;
                            stage_d = entry_stage;
                            op_d    = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            pe_q    <= '0;
            bit_q   <= '0;
            op_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            pe_q    <= pe_d;
            bit_q   <= bit_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Issue strobe is the registered busy flag gated by the same-cycle stall.
    assign en          = busy_q & ~stall;
    assign stage_index = stage_q;
    assign op_g        = op_q;
    assign pe_cycle    = pe_q;
    assign bit_cnt     = bit_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
